// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard, forwarding and mult/div busy controller
module hazard_unit_mc #(
  parameter int RA_W       = 5,
  parameter int MD_LATENCY = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] RsD,
  input  logic [RA_W-1:0] RtD,
  input  logic [RA_W-1:0] RsE,
  input  logic [RA_W-1:0] RtE,
  input  logic [RA_W-1:0] WriteRegE,
  input  logic [RA_W-1:0] WriteRegM,
  input  logic [RA_W-1:0] WriteRegW,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            MemtoRegM,
  input  logic            BranchD,
  input  logic            JumpRegD,
  input  logic            MdStartE,
  input  logic            MdUseD,
  input  logic            DmemReqM,
  input  logic            DmemReadyM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushE,
  output logic            FlushM,
  output logic            FlushW,
  output logic            MdBusy
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic memwait;
  logic lduse;
  logic brhaz;
  logic mdstall;
  logic mdclash;
  logic rs_dep_e;
  logic rt_dep_e;
  logic rs_dep_m;
  logic rt_dep_m;

  // Register 0 is hardwired zero, so it never produces a dependency.
  function automatic logic match(input logic [RA_W-1:0] x,
                                 input logic [RA_W-1:0] y,
                                 input logic            we);
    return we && (x != '0) && (x == y);
  endfunction

  assign MdBusy = (state == BUSY);

  // Hazard terms; a branch/jr needs its operands in D, so an E producer or an M load stalls it.
  always_comb begin
    rs_dep_e = match(RsD, WriteRegE, RegWriteE);
    rt_dep_e = match(RtD, WriteRegE, RegWriteE);
    rs_dep_m = MemtoRegM && match(RsD, WriteRegM, RegWriteM);
    rt_dep_m = MemtoRegM && match(RtD, WriteRegM, RegWriteM);
    memwait  = DmemReqM && !DmemReadyM;
    lduse    = MemtoRegE && (rs_dep_e || rt_dep_e);
    brhaz    = (BranchD && (rs_dep_e || rt_dep_e || rs_dep_m || rt_dep_m))
            || (JumpRegD && (rs_dep_e || rs_dep_m));
    mdstall  = MdUseD && (MdBusy || MdStartE);
    mdclash  = MdStartE && MdBusy;
  end

  // Stall/flush priority: a memory wait freezes everything, then unit clash, then D-stage hazards.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if (memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (mdclash) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (lduse || brhaz || mdstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Forward selection; the younger M result wins over W, and stalls do not gate it.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!rst) begin
      if (match(RsE, WriteRegM, RegWriteM))      ForwardAE = 2'b10;
      else if (match(RsE, WriteRegW, RegWriteW)) ForwardAE = 2'b01;
      if (match(RtE, WriteRegM, RegWriteM))      ForwardBE = 2'b10;
      else if (match(RtE, WriteRegW, RegWriteW)) ForwardBE = 2'b01;
      ForwardAD = match(RsD, WriteRegM, RegWriteM);
      ForwardBD = match(RtD, WriteRegM, RegWriteM);
    end
  end

  // Mult/div busy tracker; the countdown keeps running through memory waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (MdStartE && !StallE) begin
        state <= BUSY;
        cnt   <= CNT_W'(MD_LATENCY);
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - randomized and directed self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

  localparam int RA_W = 5;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [RA_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic            RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic            BranchD, JumpRegD, MdStartE, MdUseD, DmemReqM, DmemReadyM;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            ForwardAD, ForwardBD;
  logic            StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW, MdBusy;

  int n_checks = 0;
  int n_pass   = 0;
  int md_rem   = 0;
  int busy_cycles;
  int stall_cycles;

  hazard_unit_mc #(.RA_W(RA_W), .MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD), .MdStartE(MdStartE), .MdUseD(MdUseD),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW), .MdBusy(MdBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [13:0] dut_vec();
    return {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, StallM,
            FlushE, FlushM, FlushW, MdBusy};
  endfunction

  function automatic bit dep(input logic [RA_W-1:0] src, input logic [RA_W-1:0] dst, input logic we);
    return we && src != 0 && src == dst;
  endfunction

  // Reference: outputs from the rule table, busy from a remaining-cycle count.
  function automatic logic [13:0] model_out();
    logic [1:0] fae, fbe;
    bit busy, mw, ld, bh, ms, mc;
    bit [6:0] ctl;
    busy = md_rem > 0;
    fae = dep(RsE, WriteRegM, RegWriteM) ? 2'b10 : dep(RsE, WriteRegW, RegWriteW) ? 2'b01 : 2'b00;
    fbe = dep(RtE, WriteRegM, RegWriteM) ? 2'b10 : dep(RtE, WriteRegW, RegWriteW) ? 2'b01 : 2'b00;
    mw = DmemReqM && !DmemReadyM;
    ld = MemtoRegE && (dep(RsD, WriteRegE, RegWriteE) || dep(RtD, WriteRegE, RegWriteE));
    bh = 0;
    if (BranchD || JumpRegD) begin
      if (dep(RsD, WriteRegE, RegWriteE) || (MemtoRegM && dep(RsD, WriteRegM, RegWriteM))) bh = 1;
      if (BranchD && (dep(RtD, WriteRegE, RegWriteE) || (MemtoRegM && dep(RtD, WriteRegM, RegWriteM)))) bh = 1;
    end
    ms = MdUseD && (busy || MdStartE);
    mc = MdStartE && busy;
    // ctl = {StallF,StallD,StallE,StallM,FlushE,FlushM,FlushW}
    if (mw)                ctl = 7'b1111001;
    else if (mc)           ctl = 7'b1110010;
    else if (ld || bh || ms) ctl = 7'b1100100;
    else                   ctl = 7'b0000000;
    return {fae, fbe, dep(RsD, WriteRegM, RegWriteM), dep(RtD, WriteRegM, RegWriteM), ctl, busy};
  endfunction

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, JumpRegD, MdStartE, MdUseD, DmemReqM, DmemReadyM} = '0;
  endtask

  // Called a little after a falling edge with inputs set: check, clock, advance model.
  task automatic cycle_check(input string tag);
    bit accept;
    #1;
    check(tag, dut_vec(), model_out());
    accept = (md_rem == 0) && MdStartE && !(DmemReqM && !DmemReadyM);
    @(posedge clk);
    if (md_rem > 0) md_rem--;
    else if (accept) md_rem = LAT;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8; RsE = 8; RegWriteM = 1; WriteRegM = 8;
    DmemReqM = 1; MdUseD = 1; MdStartE = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", dut_vec(), 14'h0);
    rst = 1'b0;
    clear_inputs();
    #1;
    check("post_reset_idle", dut_vec(), 14'h0);

    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
    #1 check("lduse_stall", {StallF, StallD, FlushE, StallE}, 4'b1110);
    RsD = 0;
    #1 check("lduse_r0", dut_vec(), 14'h0);
    clear_inputs();

    RsE = 5; RtE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    #1 check("fwd_m_wins", {ForwardAE, ForwardBE}, 4'b1010);
    RegWriteM = 0;
    #1 check("fwd_w", {ForwardAE, ForwardBE}, 4'b0101);
    clear_inputs();

    BranchD = 1; RtD = 3; WriteRegE = 3; RegWriteE = 1;
    #1 check("branch_stall", {StallF, StallD, FlushE}, 3'b111);
    cycle_check("branch_stall_m");
    RegWriteE = 0; WriteRegE = 0; WriteRegM = 3; RegWriteM = 1; MemtoRegM = 0;
    #1 check("branch_fwd", {ForwardBD, StallF, StallD, FlushE}, 4'b1000);
    cycle_check("branch_fwd_m");
    clear_inputs();

    MdStartE = 1; MdUseD = 1;
    cycle_check("md_start");
    MdStartE = 0;
    busy_cycles = 0; stall_cycles = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      #1;
      if (MdBusy) busy_cycles++;
      if (StallD && MdBusy) stall_cycles++;
      cycle_check("md_busy_run");
    end
    check("md_busy_len", busy_cycles, LAT);
    check("md_stall_len", stall_cycles, LAT);
    clear_inputs();

    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RtD = 7; DmemReqM = 1; DmemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("memwait", {StallF, StallD, StallE, StallM, FlushW, FlushE}, 6'b111110);
      cycle_check("memwait_m");
    end
    DmemReadyM = 1;
    #1 check("memwait_release", {StallF, StallD, StallE, StallM, FlushE}, 5'b11001);
    cycle_check("memwait_release_m");
    clear_inputs();

    MdStartE = 1;
    cycle_check("md_start2");
    MdStartE = 0; MdUseD = 1;
    cycle_check("md_cnt3");
    cycle_check("md_cnt2");
    #1 check("busy_before_rst", MdBusy, 1'b1);
    DmemReqM = 1;
    rst = 1'b1;
    md_rem = 0;
    #1 check("rst_async_busy", MdBusy, 1'b0);
    check("rst_outputs", dut_vec(), 14'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    for (int i = 0; i < 400; i++) begin
      RsD = RA_W'($urandom_range(0, 3)); RtD = RA_W'($urandom_range(0, 3));
      RsE = RA_W'($urandom_range(0, 3)); RtE = RA_W'($urandom_range(0, 3));
      WriteRegE = RA_W'($urandom_range(0, 3)); WriteRegM = RA_W'($urandom_range(0, 3));
      WriteRegW = RA_W'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom);
      BranchD = ($urandom_range(0, 3) == 0); JumpRegD = ($urandom_range(0, 3) == 0);
      MdStartE = ($urandom_range(0, 5) == 0); MdUseD = ($urandom_range(0, 3) == 0);
      DmemReqM = 1'($urandom); DmemReadyM = ($urandom_range(0, 2) != 0);
      cycle_check("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
